// File: rtl/beamformer_pkg.sv
// rtl/beamformer_pkg.sv - shared types and constants for the delay-and-sum beamformer
// Contents: controller state enum, default channel/sample/index widths,
// and the helper that sizes the output accumulator.
package beamformer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARMED,
        ST_SUM
    } bf_state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_IDX_W  = 16;

    // Summing num_ch signed samples grows the result by log2(num_ch) bits.
    function automatic int acc_width(input int data_w, input int num_ch);
        return data_w + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/bf_delay_table.sv
// rtl/bf_delay_table.sv - one channel's delay table, DEPTH x IDX_W, registered read
// Ports:
//   clk             clock
//   wr_en/addr/data write port, one entry per cycle
//   rd_en/rd_addr   read request; rd_data valid the cycle after rd_en
//   rd_data         registered read data, held while rd_en is low
module bf_delay_table #(
    parameter int DEPTH = 64,
    parameter int IDX_W = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [IDX_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [IDX_W-1:0] rd_data
);

    logic [IDX_W-1:0] mem [DEPTH];

    // Contents are intentionally not reset; tables survive a controller reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/delay_sum_beamformer.sv
// rtl/delay_sum_beamformer.sv - multi-channel delay-and-sum beamformer
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     frame start pulse (honoured only when idle)
//   in_valid/in_ready/in_data input beats, NUM_CH packed samples, ch0 in LSBs
//   tab_wr_*                  delay-table write port (honoured only when idle)
//   out_valid/out_data        one-cycle summed point
//   out_point/out_last        point number of out_data, last-point marker
//   busy                      frame in progress
//   miss_err                  sticky per frame: a sample index was passed or
//                             the beat counter saturated
module delay_sum_beamformer
    import beamformer_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int NUM_POINTS = 64,
    parameter int PT_W       = $clog2(NUM_POINTS),
    parameter int ACC_W      = acc_width(DATA_W, NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic                       tab_wr_en,
    input  logic [$clog2(NUM_CH)-1:0]  tab_wr_ch,
    input  logic [PT_W-1:0]            tab_wr_addr,
    input  logic [IDX_W-1:0]           tab_wr_data,
    output logic                       out_valid,
    output logic [ACC_W-1:0]           out_data,
    output logic [PT_W-1:0]            out_point,
    output logic                       out_last,
    output logic                       busy,
    output logic                       miss_err
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] CNT_MAX = {IDX_W{1'b1}};
    localparam logic [PT_W-1:0]  LAST_PT = PT_W'(NUM_POINTS - 1);

    bf_state_t               state;
    logic                    load_phase;   // 0: read issued, 1: table data valid
    logic [IDX_W-1:0]        counter;
    logic [PT_W-1:0]         k;
    logic [NUM_CH-1:0]       filled;
    logic [NUM_CH-1:0]       fill_next;
    logic                    beat_miss;
    logic [IDX_W-1:0]        desired     [NUM_CH];
    logic [IDX_W-1:0]        tab_rd_data [NUM_CH];
    logic signed [DATA_W-1:0] cap        [NUM_CH];
    logic signed [ACC_W-1:0] cap_sum;
    logic                    rd_en;
    logic                    tab_we_ok;

    assign in_ready  = (state == ST_ARMED);
    assign busy      = (state != ST_IDLE);
    assign rd_en     = (state == ST_LOAD) && !load_phase;
    assign tab_we_ok = tab_wr_en && (state == ST_IDLE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_tab
        bf_delay_table #(
            .DEPTH (NUM_POINTS),
            .IDX_W (IDX_W),
            .AW    (PT_W)
        ) u_tab (
            .clk     (clk),
            .wr_en   (tab_we_ok && (tab_wr_ch == CH_W'(g))),
            .wr_addr (tab_wr_addr),
            .wr_data (tab_wr_data),
            .rd_en   (rd_en),
            .rd_addr (k),
            .rd_data (tab_rd_data[g])
        );
    end

    // Which channels complete on the current beat. A channel whose index is
    // already behind the counter completes immediately with a zero sample.
    always_comb begin
        fill_next = filled;
        beat_miss = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!filled[ch]) begin
                if (counter == desired[ch]) begin
                    fill_next[ch] = 1'b1;
                end else if (counter > desired[ch]) begin
                    fill_next[ch] = 1'b1;
                    beat_miss     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cap_sum = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cap_sum = cap_sum + ACC_W'(cap[ch]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            load_phase <= 1'b0;
            counter    <= '0;
            k          <= '0;
            filled     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_point  <= '0;
            out_last   <= 1'b0;
            miss_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        counter    <= '0;
                        k          <= '0;
                        miss_err   <= 1'b0;
                        filled     <= '0;
                        load_phase <= 1'b0;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!load_phase) begin
                        load_phase <= 1'b1;
                    end else begin
                        for (int ch = 0; ch < NUM_CH; ch++) begin
                            desired[ch] <= tab_rd_data[ch];
                        end
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (in_valid) begin
                        for (int ch = 0; ch < NUM_CH; ch++) begin
                            if (!filled[ch]) begin
                                if (counter == desired[ch]) begin
                                    cap[ch] <= in_data[ch*DATA_W +: DATA_W];
                                end else if (counter > desired[ch]) begin
                                    cap[ch] <= '0;
                                end
                            end
                        end
                        filled <= fill_next;
                        if (beat_miss || (counter == CNT_MAX)) begin
                            miss_err <= 1'b1;
                        end
                        if (counter != CNT_MAX) begin
                            counter <= counter + 1'b1;
                        end
                        if (&fill_next) begin
                            state <= ST_SUM;
                        end
                    end
                end
                ST_SUM: begin
                    out_data   <= cap_sum;
                    out_point  <= k;
                    out_valid  <= 1'b1;
                    out_last   <= (k == LAST_PT);
                    filled     <= '0;
                    load_phase <= 1'b0;
                    if (k == LAST_PT) begin
                        state <= ST_IDLE;
                    end else begin
                        k     <= k + 1'b1;
                        state <= ST_LOAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// tb/tb_delay_sum_beamformer.sv - self-checking bench for delay_sum_beamformer
module tb_delay_sum_beamformer;

    localparam int NUM_CH     = 4;
    localparam int DATA_W     = 16;
    localparam int IDX_W      = 16;
    localparam int NUM_POINTS = 2;
    localparam int PT_W       = 1;
    localparam int ACC_W      = 18;
    localparam int MEM_N      = 64;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data = '0;
    logic                     tab_wr_en = 1'b0;
    logic [1:0]               tab_wr_ch = '0;
    logic [PT_W-1:0]          tab_wr_addr = '0;
    logic [IDX_W-1:0]         tab_wr_data = '0;
    logic                     out_valid;
    logic [ACC_W-1:0]         out_data;
    logic [PT_W-1:0]          out_point;
    logic                     out_last;
    logic                     busy;
    logic                     miss_err;

    delay_sum_beamformer #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_POINTS(NUM_POINTS)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tab_wr_en(tab_wr_en), .tab_wr_ch(tab_wr_ch),
        .tab_wr_addr(tab_wr_addr), .tab_wr_data(tab_wr_data),
        .out_valid(out_valid), .out_data(out_data), .out_point(out_point),
        .out_last(out_last), .busy(busy), .miss_err(miss_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Stimulus: table contents and the sample every channel presents at each
    // value of the frame's beat counter.
    int                       tab_m    [NUM_CH][NUM_POINTS];
    logic signed [DATA_W-1:0] data_mem [MEM_N][NUM_CH];

    // Expected results.
    int exp_sum   [NUM_POINTS];
    int exp_done  [NUM_POINTS];
    int exp_start [NUM_POINTS];
    bit exp_miss;

    // Observed results.
    int got_sum   [8];
    int got_point [8];
    bit got_last  [8];
    int got_cyc   [8];
    int beat_cyc  [MEM_N];
    int n_out;
    int cycle;
    bit got_miss;

    // Each point starts at the beat after the previous point finished. A
    // channel whose index lies behind that start contributes zero and flags
    // a miss; otherwise it contributes the sample at its index. The point
    // finishes on the latest such index (or on its first beat if all miss).
    task automatic compute_model();
        int c;
        c = 0;
        exp_miss = 1'b0;
        for (int p = 0; p < NUM_POINTS; p++) begin
            int s;
            int done;
            s = 0;
            done = c;
            exp_start[p] = c;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (tab_m[ch][p] < c) begin
                    exp_miss = 1'b1;
                end else begin
                    s += int'(data_mem[tab_m[ch][p]][ch]);
                    if (tab_m[ch][p] > done) done = tab_m[ch][p];
                end
            end
            exp_sum[p]  = s;
            exp_done[p] = done;
            c = done + 1;
        end
    endtask

    task automatic write_tables();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int p = 0; p < NUM_POINTS; p++) begin
                @(negedge clk);
                tab_wr_en   = 1'b1;
                tab_wr_ch   = 2'(ch);
                tab_wr_addr = PT_W'(p);
                tab_wr_data = IDX_W'(tab_m[ch][p]);
            end
        end
        @(negedge clk);
        tab_wr_en = 1'b0;
    endtask

    task automatic setup_scenario1();
        int t0 [NUM_CH];
        int t1 [NUM_CH];
        t0 = '{2, 3, 3, 5};
        t1 = '{6, 7, 8, 8};
        for (int ch = 0; ch < NUM_CH; ch++) begin
            tab_m[ch][0] = t0[ch];
            tab_m[ch][1] = t1[ch];
        end
        for (int c = 0; c < MEM_N; c++)
            for (int ch = 0; ch < NUM_CH; ch++)
                data_mem[c][ch] = DATA_W'(c * 10 + ch);
        write_tables();
        compute_model();
    endtask

    // mode 0: in_valid held high, 1: toggles every cycle, 2: random.
    // disturb: a table write and a second start are pulsed mid-frame.
    task automatic run_frame(input int mode, input bit disturb);
        int beat_cnt;
        bit done;
        beat_cnt = 0;
        n_out = 0;
        cycle = 0;
        done = 1'b0;
        for (int i = 0; i < MEM_N; i++) beat_cyc[i] = -100;
        while (!done && cycle < 3000) begin
            if (out_valid) begin
                if (n_out < 8) begin
                    got_sum[n_out]   = int'($signed(out_data));
                    got_point[n_out] = int'(out_point);
                    got_last[n_out]  = out_last;
                    got_cyc[n_out]   = cycle;
                end
                n_out++;
            end
            if (n_out >= NUM_POINTS && !busy) begin
                done = 1'b1;
            end else begin
                start       = (cycle == 0) || (disturb && cycle == 5);
                tab_wr_en   = disturb && (cycle == 5);
                tab_wr_ch   = 2'd0;
                tab_wr_addr = PT_W'(1);
                tab_wr_data = '0;
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (cycle % 2 == 0);
                    default: in_valid = 1'($urandom_range(0, 1));
                endcase
                for (int ch = 0; ch < NUM_CH; ch++)
                    in_data[ch*DATA_W +: DATA_W] = (beat_cnt < MEM_N) ? data_mem[beat_cnt][ch] : '0;
                if (in_valid && in_ready) begin
                    if (beat_cnt < MEM_N) beat_cyc[beat_cnt] = cycle;
                    beat_cnt++;
                end
                @(negedge clk);
                cycle++;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        tab_wr_en = 1'b0;
        got_miss = miss_err;
        @(negedge clk);
        if (out_valid) n_out++;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout outputs_seen=%0d required=%0d", n_out, NUM_POINTS);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready  !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data  !== '0)   begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_point !== '0)   begin failures++; $display("FAIL reset_out_point got=%h exp=0", out_point); end
        checks++; if (out_last  !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (busy      !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (miss_err  !== 1'b0) begin failures++; $display("FAIL reset_miss_err got=%b exp=0", miss_err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        setup_scenario1();
        run_frame(0, 1'b0);
        checks++; if (n_out !== NUM_POINTS) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", n_out, NUM_POINTS); end
        for (int p = 0; p < NUM_POINTS; p++) begin
            checks++; if (got_sum[p] !== exp_sum[p]) begin failures++; $display("FAIL basic_sum%0d got=%0d exp=%0d", p, got_sum[p], exp_sum[p]); end
            checks++; if (got_point[p] !== p) begin failures++; $display("FAIL basic_point%0d got=%0d exp=%0d", p, got_point[p], p); end
            checks++; if (got_last[p] !== (p == NUM_POINTS - 1)) begin failures++; $display("FAIL basic_last%0d got=%b exp=%b", p, got_last[p], p == NUM_POINTS - 1); end
        end
        checks++; if (got_miss !== exp_miss) begin failures++; $display("FAIL basic_miss got=%b exp=%b", got_miss, exp_miss); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_miss();
        setup_scenario1();
        tab_m[0][1] = 4;
        write_tables();
        compute_model();
        run_frame(0, 1'b0);
        checks++; if (n_out !== NUM_POINTS) begin failures++; $display("FAIL miss_count got=%0d exp=%0d", n_out, NUM_POINTS); end
        for (int p = 0; p < NUM_POINTS; p++) begin
            checks++; if (got_sum[p] !== exp_sum[p]) begin failures++; $display("FAIL miss_sum%0d got=%0d exp=%0d", p, got_sum[p], exp_sum[p]); end
        end
        checks++; if (got_miss !== 1'b1) begin failures++; $display("FAIL miss_flag got=%b exp=1", got_miss); end
    endtask

    task automatic test_signed_extremes();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            tab_m[ch][0] = 0;
            tab_m[ch][1] = 1;
        end
        for (int c = 0; c < MEM_N; c++)
            for (int ch = 0; ch < NUM_CH; ch++)
                data_mem[c][ch] = (c == 0) ? -16'sd32768 : 16'sd32767;
        write_tables();
        compute_model();
        run_frame(0, 1'b0);
        checks++; if (got_sum[0] !== -131072) begin failures++; $display("FAIL extreme_neg got=%0d exp=-131072", got_sum[0]); end
        checks++; if (got_sum[1] !== exp_sum[1]) begin failures++; $display("FAIL extreme_pos got=%0d exp=%0d", got_sum[1], exp_sum[1]); end
        checks++; if (got_miss !== 1'b0) begin failures++; $display("FAIL extreme_miss got=%b exp=0", got_miss); end
    endtask

    task automatic test_toggle_valid();
        setup_scenario1();
        run_frame(1, 1'b0);
        for (int p = 0; p < NUM_POINTS; p++) begin
            checks++; if (got_sum[p] !== exp_sum[p]) begin failures++; $display("FAIL toggle_sum%0d got=%0d exp=%0d", p, got_sum[p], exp_sum[p]); end
        end
        checks++; if (got_miss !== exp_miss) begin failures++; $display("FAIL toggle_miss got=%b exp=%b", got_miss, exp_miss); end
    endtask

    task automatic test_busy_ignore();
        setup_scenario1();
        run_frame(0, 1'b1);
        checks++; if (n_out !== NUM_POINTS) begin failures++; $display("FAIL busy_count got=%0d exp=%0d", n_out, NUM_POINTS); end
        for (int p = 0; p < NUM_POINTS; p++) begin
            checks++; if (got_sum[p] !== exp_sum[p]) begin failures++; $display("FAIL busy_sum%0d got=%0d exp=%0d", p, got_sum[p], exp_sum[p]); end
        end
        checks++; if (got_miss !== 1'b0) begin failures++; $display("FAIL busy_miss got=%b exp=0", got_miss); end
    endtask

    task automatic test_reset_mid();
        bit seen_out;
        setup_scenario1();
        seen_out = 1'b0;
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b1;
        in_data = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen_out = 1'b1;
        end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_armed got=%b exp=1", in_ready); end
        rst = 1'b1;
        @(negedge clk);
        if (out_valid) seen_out = 1'b1;
        checks++; if ({in_ready, out_valid, out_last, busy, miss_err} !== 5'b0) begin failures++; $display("FAIL midreset_flags got=%b exp=00000", {in_ready, out_valid, out_last, busy, miss_err}); end
        checks++; if ({out_data, out_point} !== '0) begin failures++; $display("FAIL midreset_data got=%h exp=0", {out_data, out_point}); end
        checks++; if (seen_out !== 1'b0) begin failures++; $display("FAIL midreset_partial got=%b exp=0", seen_out); end
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        run_frame(0, 1'b0);
        for (int p = 0; p < NUM_POINTS; p++) begin
            checks++; if (got_sum[p] !== exp_sum[p]) begin failures++; $display("FAIL midreset_sum%0d got=%0d exp=%0d", p, got_sum[p], exp_sum[p]); end
        end
    endtask

    task automatic test_timing();
        setup_scenario1();
        run_frame(0, 1'b0);
        checks++; if (n_out !== NUM_POINTS) begin failures++; $display("FAIL timing_pulses got=%0d exp=%0d", n_out, NUM_POINTS); end
        for (int p = 0; p < NUM_POINTS; p++) begin
            checks++; if (got_cyc[p] !== beat_cyc[exp_done[p]] + 2) begin failures++; $display("FAIL timing_latency%0d got=%0d exp=%0d", p, got_cyc[p], beat_cyc[exp_done[p]] + 2); end
        end
        checks++; if (beat_cyc[exp_start[1]] - beat_cyc[exp_done[0]] !== 4) begin failures++; $display("FAIL timing_gap got=%0d exp=4", beat_cyc[exp_start[1]] - beat_cyc[exp_done[0]]); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                tab_m[ch][0] = int'($urandom_range(0, 15));
                tab_m[ch][1] = tab_m[ch][0] + int'($urandom_range(0, 20));
            end
            for (int c = 0; c < MEM_N; c++)
                for (int ch = 0; ch < NUM_CH; ch++)
                    data_mem[c][ch] = DATA_W'($urandom);
            write_tables();
            compute_model();
            run_frame(2, 1'b0);
            checks++; if (n_out !== NUM_POINTS) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", f, n_out, NUM_POINTS); end
            for (int p = 0; p < NUM_POINTS; p++) begin
                checks++; if (got_sum[p] !== exp_sum[p]) begin failures++; $display("FAIL rand%0d_sum%0d got=%0d exp=%0d", f, p, got_sum[p], exp_sum[p]); end
                checks++; if (got_cyc[p] !== beat_cyc[exp_done[p]] + 2) begin failures++; $display("FAIL rand%0d_latency%0d got=%0d exp=%0d", f, p, got_cyc[p], beat_cyc[exp_done[p]] + 2); end
            end
            checks++; if (got_miss !== exp_miss) begin failures++; $display("FAIL rand%0d_miss got=%b exp=%b", f, got_miss, exp_miss); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_miss();
        test_signed_extremes();
        test_toggle_valid();
        test_busy_ignore();
        test_reset_mid();
        test_timing();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
